// File: rtl/sha512_arb_pkg.sv
// Shared types and constants for the two-requester SHA-512 core arbiter.
// Optional watchdog is enabled with SHA512_ARB_WATCHDOG_EN.
package sha512_arb_pkg;

    localparam int NUM_REQ            = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DIGEST
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/sha512_arb_wdog.sv
// Wait-state watchdog: counts cycles spent in one state, flags expiry.
// Only instantiated when SHA512_ARB_WATCHDOG_EN is defined.
module sha512_arb_wdog
    import sha512_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // The cycle holding LIMIT is the TIMEOUT_CYCLES-th cycle in the state.
    assign expire = !clear && (r_cnt == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear || expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sha512_arbiter.sv
// Round-robin arbiter locking a shared SHA-512 core to one message at a time.
// Define SHA512_ARB_WATCHDOG_EN to add the wait-state watchdog and err pulses.
module sha512_arbiter
    import sha512_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] gnt,
    output logic               core_init,
    output logic               core_next,
    input  logic               core_ready,
    input  logic               core_digest_valid,
    output logic               owner,
    output logic               busy,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err
);

    state_t             r_state;
    state_t             w_state_nw;
    state_t             w_state_n;
    logic               r_owner;
    logic               r_rr;
    logic               r_first_blk;
    logic               r_last_blk;
    logic               r_wait1;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_init;
    logic               r_next;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;

    logic               w_sel;
    logic               w_owner_n;
    logic               w_rr_n;
    logic               w_first_n;
    logic               w_last_n;
    logic               w_wait1_n;
    logic [NUM_REQ-1:0] w_gnt_n;
    logic               w_init_n;
    logic               w_next_n;
    logic [NUM_REQ-1:0] w_done_n;

    // r_rr remembers the last requester served; the other one wins a tie.
    assign w_sel = (req == 2'b11) ? ~r_rr : req[1];

    always_comb begin
        w_state_nw = r_state;
        w_owner_n  = r_owner;
        w_rr_n     = r_rr;
        w_first_n  = r_first_blk;
        w_last_n   = r_last_blk;
        w_wait1_n  = 1'b0;
        w_gnt_n    = '0;
        w_init_n   = 1'b0;
        w_next_n   = 1'b0;
        w_done_n   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (core_ready && (req != '0)) begin
                    w_owner_n  = w_sel;
                    w_first_n  = 1'b1;
                    w_state_nw = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_gnt_n    = onehot(r_owner);
                w_init_n   = r_first_blk;
                w_next_n   = !r_first_blk;
                w_first_n  = 1'b0;
                w_last_n   = req_last[r_owner];
                w_wait1_n  = 1'b1;
                w_state_nw = S_WAIT;
            end
            S_WAIT: begin
                // core_ready may still be stale in the cycle after the pulse
                if (!r_wait1 && core_ready) begin
                    w_state_nw = r_last_blk ? S_DIGEST : S_HOLD;
                end
            end
            S_HOLD: begin
                if (req[r_owner]) begin
                    w_state_nw = S_ISSUE;
                end
            end
            S_DIGEST: begin
                if (core_digest_valid) begin
                    w_done_n   = onehot(r_owner);
                    w_rr_n     = r_owner;
                    w_state_nw = S_IDLE;
                end
            end
            default: begin
                w_state_nw = S_IDLE;
            end
        endcase
    end

`ifdef SHA512_ARB_WATCHDOG_EN
    logic               w_clear;
    logic               w_expire;
    logic [NUM_REQ-1:0] r_err;

    assign w_clear = (w_state_nw != r_state) ||
                     !(r_state inside {S_WAIT, S_HOLD, S_DIGEST});
    assign w_state_n = w_expire ? S_IDLE : w_state_nw;
    assign err       = r_err;

    sha512_arb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .expire(w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= '0;
        end else begin
            r_err <= w_expire ? onehot(r_owner) : '0;
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_state_n    = w_state_nw;
    assign err          = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_rr        <= 1'b1;
            r_first_blk <= 1'b0;
            r_last_blk  <= 1'b0;
            r_wait1     <= 1'b0;
            r_gnt       <= '0;
            r_init      <= 1'b0;
            r_next      <= 1'b0;
            r_done      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_owner     <= w_owner_n;
            r_rr        <= w_rr_n;
            r_first_blk <= w_first_n;
            r_last_blk  <= w_last_n;
            r_wait1     <= w_wait1_n;
            r_gnt       <= w_gnt_n;
            r_init      <= w_init_n;
            r_next      <= w_next_n;
            r_done      <= w_done_n;
            r_busy      <= (w_state_n != S_IDLE);
        end
    end

    assign gnt       = r_gnt;
    assign core_init = r_init;
    assign core_next = r_next;
    assign done      = r_done;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule

// File: tb/tb_sha512_arbiter.sv
// Testbench for sha512_arbiter: directed scenarios plus a randomized
// transaction-level run against a message/round-robin reference model.
module tb_sha512_arbiter;

`ifdef SHA512_ARB_WATCHDOG_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] req_last;
    logic [1:0] gnt;
    logic       core_init;
    logic       core_next;
    logic       core_ready;
    logic       core_digest_valid;
    logic       owner;
    logic       busy;
    logic [1:0] done;
    logic [1:0] err;

    int vec  = 0;
    int miss = 0;

    sha512_arbiter #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_last         (req_last),
        .gnt              (gnt),
        .core_init        (core_init),
        .core_next        (core_next),
        .core_ready       (core_ready),
        .core_digest_valid(core_digest_valid),
        .owner            (owner),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [1:0] oh(input int i);
        logic [1:0] one;
        one = 2'b01;
        return one << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b0;
        req               = '0;
        req_last          = '0;
        core_ready        = 1'b0;
        core_digest_valid = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        core_ready = 1'b1;
    endtask

    task automatic grab(output logic [1:0] g, output logic ini,
                        output logic nxt);
        g   = '0;
        ini = 1'b0;
        nxt = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (gnt != 2'b00) begin
                g   = gnt;
                ini = core_init;
                nxt = core_next;
                break;
            end
        end
    endtask

    task automatic core_work();
        core_ready = 1'b0;
        tick();
        tick();
        core_ready = 1'b1;
    endtask

    task automatic wait_done(output logic [1:0] d, output logic b);
        d = '0;
        b = 1'b1;
        core_digest_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (done != 2'b00) begin
                d = done;
                b = busy;
                break;
            end
        end
        core_digest_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        req               = 2'b11;
        req_last          = 2'b11;
        core_ready        = 1'b1;
        core_digest_valid = 1'b1;
        tick();
        vec++;
        if ({gnt, core_init, core_next, done, err, busy, owner} !== 10'b0) begin
            miss++;
            $display("FAIL reset_state got=%b want=0",
                     {gnt, core_init, core_next, done, err, busy, owner});
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [1:0] d;
        logic       b;
        do_reset();
        req      = 2'b01;
        req_last = 2'b01;
        tick();
        vec++;
        if ({busy, owner, gnt, core_init} !== 5'b10000) begin
            miss++;
            $display("FAIL single_edge1 got=%b want=10000",
                     {busy, owner, gnt, core_init});
        end
        tick();
        vec++;
        if ({gnt, core_init, core_next} !== 4'b0110) begin
            miss++;
            $display("FAIL single_edge2 got=%b want=0110",
                     {gnt, core_init, core_next});
        end
        req = 2'b00;
        core_work();
        wait_done(d, b);
        vec++;
        if ({d, b} !== 3'b010) begin
            miss++;
            $display("FAIL single_done got=%b want=010", {d, b});
        end
        tick();
        vec++;
        if ({done, busy} !== 3'b000) begin
            miss++;
            $display("FAIL single_after got=%b want=000", {done, busy});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g, d;
        logic       i, n, b;
        logic [1:0] want [3];
        want[0] = 2'b01;
        want[1] = 2'b10;
        want[2] = 2'b01;
        do_reset();
        req_last = 2'b11;
        req      = 2'b11;
        for (int m = 0; m < 3; m++) begin
            grab(g, i, n);
            vec++;
            if ({g, i, n} !== {want[m], 2'b10}) begin
                miss++;
                $display("FAIL rr_grant%0d got=%b want=%b", m,
                         {g, i, n}, {want[m], 2'b10});
            end
            req = (m == 2) ? 2'b00 : (2'b11 & ~want[m]);
            core_work();
            wait_done(d, b);
            vec++;
            if (d !== want[m]) begin
                miss++;
                $display("FAIL rr_done%0d got=%b want=%b", m, d, want[m]);
            end
            if (m == 0) req = 2'b11;
        end
    endtask

    task automatic test_multi_block();
        logic [1:0] g, d;
        logic       i, n, b;
        do_reset();
        req      = 2'b11;
        req_last = 2'b10;
        for (int k = 0; k < 3; k++) begin
            grab(g, i, n);
            vec++;
            if ({g, i, n} !== {2'b01, (k == 0), (k != 0)}) begin
                miss++;
                $display("FAIL multi_blk%0d got=%b want=%b", k, {g, i, n},
                         {2'b01, (k == 0), (k != 0)});
            end
            if (k == 1) req_last = 2'b11;
            if (k == 2) req = 2'b10;
            core_work();
        end
        wait_done(d, b);
        vec++;
        if ({d, b} !== 3'b010) begin
            miss++;
            $display("FAIL multi_done0 got=%b want=010", {d, b});
        end
        grab(g, i, n);
        vec++;
        if ({g, i, n} !== 4'b1010) begin
            miss++;
            $display("FAIL multi_req1 got=%b want=1010", {g, i, n});
        end
        req = 2'b00;
        core_work();
        wait_done(d, b);
        vec++;
        if (d !== 2'b10) begin
            miss++;
            $display("FAIL multi_done1 got=%b want=10", d);
        end
    endtask

    task automatic test_reset_hold();
        logic [1:0] g, d;
        logic       i, n, b;
        do_reset();
        req      = 2'b10;
        req_last = 2'b00;
        grab(g, i, n);
        req = 2'b00;
        core_work();
        tick();
        tick();
        vec++;
        if ({g, i, busy, owner} !== 5'b10111) begin
            miss++;
            $display("FAIL hold_entry got=%b want=10111", {g, i, busy, owner});
        end
        #2 reset = 1'b0;
        #1;
        vec++;
        if ({gnt, core_init, core_next, done, err, busy, owner} !== 10'b0) begin
            miss++;
            $display("FAIL hold_async_reset got=%b want=0",
                     {gnt, core_init, core_next, done, err, busy, owner});
        end
        tick();
        reset    = 1'b1;
        req      = 2'b10;
        req_last = 2'b10;
        grab(g, i, n);
        vec++;
        if ({g, i, n} !== 4'b1010) begin
            miss++;
            $display("FAIL hold_restart got=%b want=1010", {g, i, n});
        end
        req = 2'b00;
        core_work();
        wait_done(d, b);
        vec++;
        if (d !== 2'b10) begin
            miss++;
            $display("FAIL hold_restart_done got=%b want=10", d);
        end
    endtask

`ifdef SHA512_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        logic [1:0] g;
        logic       i, n;
        do_reset();
        req      = 2'b01;
        req_last = 2'b01;
        grab(g, i, n);
        req        = 2'b00;
        core_ready = 1'b0;
        for (int k = 1; k < TMO; k++) tick();
        vec++;
        if ({err, busy} !== 3'b001) begin
            miss++;
            $display("FAIL wdog_early got=%b want=001", {err, busy});
        end
        tick();
        vec++;
        if (err !== 2'b01) begin
            miss++;
            $display("FAIL wdog_err got=%b want=01", err);
        end
        tick();
        vec++;
        if ({err, busy} !== 3'b000) begin
            miss++;
            $display("FAIL wdog_release got=%b want=000", {err, busy});
        end
        core_ready = 1'b1;
        req        = 2'b01;
        grab(g, i, n);
        vec++;
        if ({g, i, n} !== 4'b0110) begin
            miss++;
            $display("FAIL wdog_restart got=%b want=0110", {g, i, n});
        end
        req = 2'b00;
        do_reset();
    endtask
`endif

    task automatic test_random();
        int         pend [2];
        bit         up   [2];
        int         rdy_cnt, lock, dig, exp_o, gi, started, finished, cyc;
        bit         init_due, rr_last, rose, gthis, ok;
        logic [1:0] rq_prev;
        logic       rdy_prev, bsy_prev, dv_prev;
        do_reset();
        pend[0]  = 0;
        pend[1]  = 0;
        up[0]    = 0;
        up[1]    = 0;
        lock     = -1;
        dig      = -1;
        exp_o    = 0;
        rr_last  = 1'b1;
        rdy_cnt  = 0;
        init_due = 0;
        started  = 0;
        finished = 0;
        rq_prev  = '0;
        rdy_prev = 1'b1;
        bsy_prev = 1'b0;
        dv_prev  = 1'b0;
        cyc      = 0;
        while (cyc < 8000) begin
            tick();
            cyc++;
            if (cyc > 2000 && started == finished &&
                pend[0] == 0 && pend[1] == 0) break;
            gthis = 0;
            vec++;
            if ({err, core_init & core_next} !== 3'b000) begin
                miss++;
                $display("FAIL rnd_excl err=%b both=%b want 0",
                         err, core_init & core_next);
            end
            rose = busy && !bsy_prev;
            if (rose) begin
                exp_o = (rq_prev == 2'b11) ? int'(!rr_last) : int'(rq_prev[1]);
                ok = rdy_prev && (rq_prev != 0) && (lock < 0) &&
                     (owner == exp_o[0]) && (gnt == 2'b00);
                vec++;
                if (!ok) begin
                    miss++;
                    $display("FAIL rnd_select owner=%b gnt=%b want owner=%0d",
                             owner, gnt, exp_o);
                end
                init_due = 1;
            end else if (init_due) begin
                init_due = 0;
                vec++;
                if ({gnt, core_init, core_next} !== {oh(exp_o), 2'b10}) begin
                    miss++;
                    $display("FAIL rnd_init got=%b want=%b",
                             {gnt, core_init, core_next}, {oh(exp_o), 2'b10});
                end
            end else if (gnt != 2'b00) begin
                ok = (lock >= 0) && (dig < 0) && rq_prev[lock[0]] &&
                     ({gnt, core_init, core_next} == {oh(lock), 2'b01});
                vec++;
                if (!ok) begin
                    miss++;
                    $display("FAIL rnd_next got=%b lock=%0d",
                             {gnt, core_init, core_next}, lock);
                end
            end
            if (done != 2'b00) begin
                ok = (dig >= 0) && (done == oh(dig)) && !busy && dv_prev;
                vec++;
                if (!ok) begin
                    miss++;
                    $display("FAIL rnd_done got=%b busy=%b want owner=%0d",
                             done, busy, dig);
                end
                if (dig >= 0) rr_last = dig[0];
                lock = -1;
                dig  = -1;
                finished++;
                core_digest_valid = 1'b0;
            end else if (bsy_prev && !busy) begin
                vec++;
                miss++;
                $display("FAIL rnd_busy_drop got=0 want=1");
            end
            if (gnt != 2'b00) begin
                gthis = 1;
                gi    = int'(gnt[1]);
                lock  = gi;
                up[gi] = 0;
                if (pend[gi] > 0) pend[gi]--;
                if (pend[gi] == 0) dig = gi;
                core_ready = 1'b0;
                rdy_cnt    = 1 + int'($urandom % 4);
            end
            if (!gthis) begin
                if (rdy_cnt > 0) begin
                    rdy_cnt--;
                    if (rdy_cnt == 0) begin
                        core_ready = 1'b1;
                        if (dig >= 0) core_digest_valid = 1'b1;
                    end
                end else if (lock < 0) begin
                    core_ready = ($urandom % 4) != 0;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (pend[r] == 0 && cyc < 2000 && ($urandom % 6) == 0) begin
                    pend[r] = 1 + int'($urandom % 3);
                    started++;
                end
                if (pend[r] != 0 && !up[r] && ($urandom % 3) != 0) up[r] = 1;
                req[r]      = up[r];
                req_last[r] = (pend[r] == 1);
            end
            rq_prev  = req;
            rdy_prev = core_ready;
            bsy_prev = busy;
            dv_prev  = core_digest_valid;
        end
        vec++;
        if (started != finished || started == 0) begin
            miss++;
            $display("FAIL rnd_drain finished=%0d started=%0d",
                     finished, started);
        end
    endtask

    initial begin
        reset             = 1'b0;
        req               = '0;
        req_last          = '0;
        core_ready        = 1'b0;
        core_digest_valid = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_multi_block();
        test_reset_hold();
`ifdef SHA512_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
